// File: rtl/ddr_req_arbiter_if.sv
// Requester-side and DDR2 af/wdf-side signals of ddr_req_arbiter.
// slave: arbiter view; master: requesters plus DDR controller view.
interface ddr_req_arbiter_if #(
   parameter int NREQ = 3,
   parameter int AW   = 31
);
   logic [NREQ-1:0]      req_valid;
   logic [3*NREQ-1:0]    req_cmd;
   logic [AW*NREQ-1:0]   req_addr;
   logic [128*NREQ-1:0]  req_wdf_din;
   logic [16*NREQ-1:0]   req_wdf_mask;
   logic [NREQ-1:0]      grant;
   logic [NREQ-1:0]      beat_ack;
   logic [NREQ-1:0]      req_done;
   logic                 af_full;
   logic                 wdf_full;
   logic [AW-1:0]        af_addr_din;
   logic [2:0]           af_cmd_din;
   logic                 af_wr_en;
   logic [127:0]         wdf_din;
   logic [15:0]          wdf_mask_din;
   logic                 wdf_wr_en;

   modport slave (
      input  req_valid, req_cmd, req_addr, req_wdf_din, req_wdf_mask, af_full, wdf_full,
      output grant, beat_ack, req_done, af_addr_din, af_cmd_din, af_wr_en,
             wdf_din, wdf_mask_din, wdf_wr_en
   );

   modport master (
      output req_valid, req_cmd, req_addr, req_wdf_din, req_wdf_mask, af_full, wdf_full,
      input  grant, beat_ack, req_done, af_addr_din, af_cmd_din, af_wr_en,
             wdf_din, wdf_mask_din, wdf_wr_en
   );
endinterface

// File: rtl/ddr_req_arbiter.sv
// Round-robin arbiter sharing the DDR2 af/wdf request port; writes stay locked for both wdf beats.
// Optional macro DDR_ARB_PRIO0_EN: requester 0 gets strict priority and does not advance the rr pointer.
module ddr_req_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 31
) (
   input logic          clk,
   input logic          rst,
   ddr_req_arbiter_if.slave bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, CMD, BEAT2} state_t;

   state_t          state, state_n;
   logic [NREQ-1:0] grant_q, grant_n;
   logic [IW-1:0]   gidx, gidx_n;
   logic [IW-1:0]   rr_ptr, rr_n;
   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   gidx_inc;
   logic            pick_found;
   logic            is_write;
   logic            cmd_push;
   logic            beat2_push;

   logic [AW-1:0]   sel_addr;
   logic [2:0]      sel_cmd;
   logic [127:0]    sel_din;
   logic [15:0]     sel_mask;

   // Field mux follows the registered grant; idle port presents zeros with a fully masked beat.
   always_comb begin
      int unsigned g;
      g        = 32'(gidx);
      sel_addr = '0;
      sel_cmd  = '0;
      sel_din  = '0;
      sel_mask = '1;
      if (grant_q != '0) begin
         sel_addr = bus.req_addr[g*AW +: AW];
         sel_cmd  = bus.req_cmd[g*3 +: 3];
         sel_din  = bus.req_wdf_din[g*128 +: 128];
         sel_mask = bus.req_wdf_mask[g*16 +: 16];
      end
   end

   assign is_write   = (state != IDLE) && (sel_cmd == 3'b000);
   assign cmd_push   = (state == CMD) && !rst && !bus.af_full && (!is_write || !bus.wdf_full);
   assign beat2_push = (state == BEAT2) && !rst && !bus.wdf_full;
   assign gidx_inc   = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;

   always_comb begin
      int unsigned j;
      pick_found = 1'b0;
      pick_idx   = '0;
      j          = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         j = 32'(rr_ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         if (!pick_found && bus.req_valid[j]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(j);
         end
      end
`ifdef DDR_ARB_PRIO0_EN
      if (bus.req_valid[0]) begin
         pick_found = 1'b1;
         pick_idx   = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grant_q <= '0;
         gidx    <= '0;
         rr_ptr  <= '0;
      end else begin
         state   <= state_n;
         grant_q <= grant_n;
         gidx    <= gidx_n;
         rr_ptr  <= rr_n;
      end
   end

   always_comb begin
      state_n = state;
      grant_n = grant_q;
      gidx_n  = gidx;
      rr_n    = rr_ptr;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_n = CMD;
               gidx_n  = pick_idx;
               grant_n = NREQ'(1) << pick_idx;
            end
         end
         CMD: begin
            if (cmd_push) begin
               if (is_write) begin
                  state_n = BEAT2;
               end else begin
                  state_n = IDLE;
                  grant_n = '0;
                  rr_n    = gidx_inc;
               end
            end
         end
         BEAT2: begin
            if (beat2_push) begin
               state_n = IDLE;
               grant_n = '0;
               rr_n    = gidx_inc;
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
`ifdef DDR_ARB_PRIO0_EN
      if (gidx == '0) rr_n = rr_ptr;
`endif
   end

   // Pushes are gated by rst so an abandoned transaction issues nothing in the reset cycle.
   always_comb begin
      bus.af_wr_en  = 1'b0;
      bus.wdf_wr_en = 1'b0;
      bus.beat_ack  = '0;
      bus.req_done  = '0;
      if (cmd_push) begin
         bus.af_wr_en = 1'b1;
         if (is_write) begin
            bus.wdf_wr_en = 1'b1;
            bus.beat_ack  = grant_q;
         end else begin
            bus.req_done = grant_q;
         end
      end
      if (beat2_push) begin
         bus.wdf_wr_en = 1'b1;
         bus.beat_ack  = grant_q;
         bus.req_done  = grant_q;
      end
   end

   assign bus.grant        = grant_q;
   assign bus.af_addr_din  = sel_addr;
   assign bus.af_cmd_din   = sel_cmd;
   assign bus.wdf_din      = sel_din;
   assign bus.wdf_mask_din = sel_mask;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed self-checking bench for ddr_req_arbiter (NREQ=3, AW=31).
// Each step: inputs change 1 ns after a rising edge, outputs are checked 1 ns later.
module tb_ddr_req_arbiter;
   localparam int N  = 3;
   localparam int AW = 31;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   ddr_req_arbiter_if #(.NREQ(N), .AW(AW)) bus ();

   ddr_req_arbiter #(.NREQ(N), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] c, input logic [AW-1:0] a,
                          input logic [127:0] d, input logic [15:0] m);
      bus.req_cmd[i*3 +: 3]        = c;
      bus.req_addr[i*AW +: AW]     = a;
      bus.req_wdf_din[i*128 +: 128] = d;
      bus.req_wdf_mask[i*16 +: 16] = m;
   endtask

   task automatic do_reset();
      step();
      rst = 1'b1;
      bus.req_valid = '0;
      bus.af_full   = 1'b0;
      bus.wdf_full  = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = '0; bus.req_cmd = '0; bus.req_addr = '0;
      bus.req_wdf_din = '0; bus.req_wdf_mask = '0;
      bus.af_full = 1'b0; bus.wdf_full = 1'b0;
      step(); step();
      rst = 1'b0;
      #1;
      checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL rst_grant: got %b want 000", bus.grant); end
      checks++; if (bus.af_wr_en !== 1'b0 || bus.wdf_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got af=%b wdf=%b want 0 0", bus.af_wr_en, bus.wdf_wr_en); end
      checks++; if (bus.beat_ack !== 3'b000 || bus.req_done !== 3'b000) begin errors++; $display("FAIL rst_pulses: got ack=%b done=%b want 000 000", bus.beat_ack, bus.req_done); end
      checks++; if (bus.wdf_mask_din !== 16'hFFFF) begin errors++; $display("FAIL rst_mask: got %h want ffff", bus.wdf_mask_din); end
      checks++; if (bus.af_addr_din !== '0 || bus.wdf_din !== '0 || bus.af_cmd_din !== 3'b000) begin errors++; $display("FAIL rst_mux: got addr=%h cmd=%b din=%h want zeros", bus.af_addr_din, bus.af_cmd_din, bus.wdf_din); end
   endtask

   task automatic test_single_write();
      logic [127:0] b0, b1;
      b0 = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
      b1 = {32'hB111_0003, 32'hB111_0002, 32'hB111_0001, 32'hB111_0000};
      set_req(0, 3'b000, 31'h0010_0000, b0, 16'h0000);
      step();
      bus.req_valid = 3'b001;
      #1;
      checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL wr_latency: got %b want 000", bus.grant); end
      step(); #1;
      checks++; if (bus.grant !== 3'b001) begin errors++; $display("FAIL wr_grant: got %b want 001", bus.grant); end
      checks++; if (bus.af_wr_en !== 1'b1 || bus.wdf_wr_en !== 1'b1) begin errors++; $display("FAIL wr_beat0_push: got af=%b wdf=%b want 1 1", bus.af_wr_en, bus.wdf_wr_en); end
      checks++; if (bus.beat_ack !== 3'b001 || bus.req_done !== 3'b000) begin errors++; $display("FAIL wr_beat0_ack: got ack=%b done=%b want 001 000", bus.beat_ack, bus.req_done); end
      checks++; if (bus.af_addr_din !== 31'h0010_0000 || bus.af_cmd_din !== 3'b000) begin errors++; $display("FAIL wr_af: got addr=%h cmd=%b want 00100000 000", bus.af_addr_din, bus.af_cmd_din); end
      checks++; if (bus.wdf_din !== b0 || bus.wdf_mask_din !== 16'h0000) begin errors++; $display("FAIL wr_beat0_data: got %h/%h want %h/0000", bus.wdf_din, bus.wdf_mask_din, b0); end
      step();
      bus.req_wdf_din[127:0] = b1;
      #1;
      checks++; if (bus.af_wr_en !== 1'b0 || bus.wdf_wr_en !== 1'b1) begin errors++; $display("FAIL wr_beat1_push: got af=%b wdf=%b want 0 1", bus.af_wr_en, bus.wdf_wr_en); end
      checks++; if (bus.beat_ack !== 3'b001 || bus.req_done !== 3'b001 || bus.grant !== 3'b001) begin errors++; $display("FAIL wr_beat1_done: got ack=%b done=%b grant=%b want 001 001 001", bus.beat_ack, bus.req_done, bus.grant); end
      checks++; if (bus.wdf_din !== b1) begin errors++; $display("FAIL wr_beat1_data: got %h want %h", bus.wdf_din, b1); end
      step();
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.grant !== 3'b000 || bus.wdf_wr_en !== 1'b0) begin errors++; $display("FAIL wr_end: got grant=%b wdf=%b want 000 0", bus.grant, bus.wdf_wr_en); end
   endtask

   task automatic test_read();
      set_req(1, 3'b001, 31'h0044_0040, 128'h0, 16'h0);
      set_req(2, 3'b101, 31'h0055_0080, 128'h0, 16'h0);
      step();
      bus.req_valid = 3'b010;
      #1;
      checks++; if (bus.wdf_wr_en !== 1'b0) begin errors++; $display("FAIL rd_idle_wdf: got %b want 0", bus.wdf_wr_en); end
      step(); #1;
      checks++; if (bus.grant !== 3'b010 || bus.af_wr_en !== 1'b1 || bus.af_cmd_din !== 3'b001) begin errors++; $display("FAIL rd_push: got grant=%b af=%b cmd=%b want 010 1 001", bus.grant, bus.af_wr_en, bus.af_cmd_din); end
      checks++; if (bus.wdf_wr_en !== 1'b0 || bus.beat_ack !== 3'b000) begin errors++; $display("FAIL rd_no_wdf: got wdf=%b ack=%b want 0 000", bus.wdf_wr_en, bus.beat_ack); end
      checks++; if (bus.req_done !== 3'b010 || bus.af_addr_din !== 31'h0044_0040) begin errors++; $display("FAIL rd_done: got done=%b addr=%h want 010 00440040", bus.req_done, bus.af_addr_din); end
      step();
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.grant !== 3'b000 || bus.af_wr_en !== 1'b0 || bus.wdf_wr_en !== 1'b0) begin errors++; $display("FAIL rd_end: got grant=%b af=%b wdf=%b want 000 0 0", bus.grant, bus.af_wr_en, bus.wdf_wr_en); end
      // Unknown command code travels as a read-type af entry.
      bus.req_valid = 3'b100;
      step(); #1;
      checks++; if (bus.grant !== 3'b100 || bus.af_wr_en !== 1'b1 || bus.af_cmd_din !== 3'b101) begin errors++; $display("FAIL odd_cmd_push: got grant=%b af=%b cmd=%b want 100 1 101", bus.grant, bus.af_wr_en, bus.af_cmd_din); end
      checks++; if (bus.wdf_wr_en !== 1'b0 || bus.req_done !== 3'b100) begin errors++; $display("FAIL odd_cmd_done: got wdf=%b done=%b want 0 100", bus.wdf_wr_en, bus.req_done); end
      step();
      bus.req_valid = 3'b000;
   endtask

   task automatic test_round_robin();
      int exp;
      logic [2:0]    oh;
      logic [AW-1:0] a;
      logic [31:0]   w;
      do_reset();
      for (int i = 0; i < N; i++) begin
         w = 32'hC0DE_0000 + 32'(i);
         set_req(i, 3'b000, AW'(32'h0020_0000 + 32'(i) * 32'h10), {4{w}}, 16'(1 << i));
      end
      bus.req_valid = 3'b111;
      #1;
      checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL rr_idle: got %b want 000", bus.grant); end
      for (int t = 0; t < 4; t++) begin
`ifdef DDR_ARB_PRIO0_EN
         exp = 0;
`else
         exp = t % N;
`endif
         oh = 3'b001 << exp;
         a  = AW'(32'h0020_0000 + 32'(exp) * 32'h10);
         w  = 32'hC0DE_0000 + 32'(exp);
         step(); #1;
         checks++; if (bus.grant !== oh || bus.beat_ack !== oh || bus.af_wr_en !== 1'b1) begin errors++; $display("FAIL rr_cmd[%0d]: got grant=%b ack=%b af=%b want %b %b 1", t, bus.grant, bus.beat_ack, bus.af_wr_en, oh, oh); end
         checks++; if (bus.af_addr_din !== a || bus.wdf_mask_din !== 16'(1 << exp)) begin errors++; $display("FAIL rr_addr[%0d]: got %h/%h want %h/%h", t, bus.af_addr_din, bus.wdf_mask_din, a, 16'(1 << exp)); end
         step(); #1;
         checks++; if (bus.grant !== oh || bus.req_done !== oh || bus.wdf_wr_en !== 1'b1 || bus.af_wr_en !== 1'b0) begin errors++; $display("FAIL rr_beat2[%0d]: got grant=%b done=%b wdf=%b af=%b want %b %b 1 0", t, bus.grant, bus.req_done, bus.wdf_wr_en, bus.af_wr_en, oh, oh); end
         checks++; if (bus.wdf_din !== {4{w}}) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", t, bus.wdf_din, {4{w}}); end
         step(); #1;
         checks++; if (bus.grant !== 3'b000 || bus.wdf_wr_en !== 1'b0) begin errors++; $display("FAIL rr_gap[%0d]: got grant=%b wdf=%b want 000 0", t, bus.grant, bus.wdf_wr_en); end
      end
      bus.req_valid = 3'b000;
   endtask

   task automatic test_backpressure();
      logic [127:0] e0;
      e0 = {4{32'hE0E0_1234}};
      do_reset();
      set_req(0, 3'b000, 31'h0030_0000, e0, 16'h00FF);
      bus.req_valid = 3'b001;
      bus.af_full   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(); #1;
         checks++; if (bus.af_wr_en !== 1'b0 || bus.wdf_wr_en !== 1'b0 || bus.beat_ack !== 3'b000) begin errors++; $display("FAIL bp_af_stall[%0d]: got af=%b wdf=%b ack=%b want 0 0 000", k, bus.af_wr_en, bus.wdf_wr_en, bus.beat_ack); end
         checks++; if (bus.grant !== 3'b001 || bus.af_addr_din !== 31'h0030_0000 || bus.wdf_mask_din !== 16'h00FF) begin errors++; $display("FAIL bp_af_stable[%0d]: got grant=%b addr=%h mask=%h want 001 00300000 00ff", k, bus.grant, bus.af_addr_din, bus.wdf_mask_din); end
      end
      step();
      bus.af_full = 1'b0;
      #1;
      checks++; if (bus.af_wr_en !== 1'b1 || bus.wdf_wr_en !== 1'b1 || bus.beat_ack !== 3'b001) begin errors++; $display("FAIL bp_af_release: got af=%b wdf=%b ack=%b want 1 1 001", bus.af_wr_en, bus.wdf_wr_en, bus.beat_ack); end
      for (int k = 0; k < 3; k++) begin
         step();
         bus.wdf_full = 1'b1;
         #1;
         checks++; if (bus.wdf_wr_en !== 1'b0 || bus.af_wr_en !== 1'b0 || bus.req_done !== 3'b000) begin errors++; $display("FAIL bp_wdf_stall[%0d]: got wdf=%b af=%b done=%b want 0 0 000", k, bus.wdf_wr_en, bus.af_wr_en, bus.req_done); end
         checks++; if (bus.grant !== 3'b001 || bus.wdf_din !== e0) begin errors++; $display("FAIL bp_wdf_stable[%0d]: got grant=%b din=%h want 001 %h", k, bus.grant, bus.wdf_din, e0); end
      end
      step();
      bus.wdf_full = 1'b0;
      #1;
      checks++; if (bus.wdf_wr_en !== 1'b1 || bus.req_done !== 3'b001 || bus.beat_ack !== 3'b001) begin errors++; $display("FAIL bp_wdf_release: got wdf=%b done=%b ack=%b want 1 001 001", bus.wdf_wr_en, bus.req_done, bus.beat_ack); end
      step();
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL bp_end: got grant=%b want 000", bus.grant); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_req(0, 3'b001, 31'h0060_0000, 128'h0, 16'h0);
      set_req(1, 3'b001, 31'h0061_0000, 128'h0, 16'h0);
      set_req(2, 3'b000, 31'h0062_0000, {4{32'hF00D_F00D}}, 16'h0);
      bus.req_valid = 3'b010;
      step();                      // CMD: read by requester 1, rr moves to 2
      step();
      bus.req_valid = 3'b100;      // IDLE
      step();                      // CMD: write beat 0 by requester 2
      step();
      rst = 1'b1;                  // BEAT2 with reset asserted
      #1;
      checks++; if (bus.wdf_wr_en !== 1'b0 || bus.req_done !== 3'b000 || bus.beat_ack !== 3'b000) begin errors++; $display("FAIL rstmid_gate: got wdf=%b done=%b ack=%b want 0 000 000", bus.wdf_wr_en, bus.req_done, bus.beat_ack); end
      step();
      rst = 1'b0;
      bus.req_valid = 3'b101;
      #1;
      checks++; if (bus.grant !== 3'b000 || bus.af_wr_en !== 1'b0 || bus.wdf_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_after: got grant=%b af=%b wdf=%b want 000 0 0", bus.grant, bus.af_wr_en, bus.wdf_wr_en); end
      step(); #1;
      checks++; if (bus.grant !== 3'b001 || bus.af_addr_din !== 31'h0060_0000) begin errors++; $display("FAIL rstmid_restart: got grant=%b addr=%h want 001 00600000", bus.grant, bus.af_addr_din); end
      bus.req_valid = 3'b000;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
